// File: rtl/tel_sched.sv
// tel_sched: periodic temperature report scheduler, PC command decoder
// and single-owner arbiter for the shared uart_tx byte transmitter.
//
// Parameters: PERIOD (report period in clk cycles), PERIOD_W (counter width).
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   t_data[15:0]       - raw DS18B20 reading (LSB = 1/16 degC)
//   rx_data[7:0]/rx_vld- command byte from uart_rx
//   tx_busy            - uart_tx shifting a frame
//   tx_data[7:0]/tx_vld- byte and one-cycle strobe to uart_tx
//   led[3:0]           - LED pattern register
//   beep_mute          - forces the beep block silent
// Build option: define TEL_CHECKSUM_EN to append byte1^byte2 to reports.
module tel_sched #(
    parameter int unsigned PERIOD   = 75_000_000,
    parameter int unsigned PERIOD_W = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] t_data,
    input  logic [7:0]  rx_data,
    input  logic        rx_vld,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_vld,
    output logic [3:0]  led,
    output logic        beep_mute
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_HI,
        WAIT_LO
    } state_t;

`ifdef TEL_CHECKSUM_EN
    localparam logic [1:0] REP_LAST = 2'd3;
`else
    localparam logic [1:0] REP_LAST = 2'd2;
`endif

    localparam logic [PERIOD_W-1:0] CNT_MAX = PERIOD_W'(PERIOD - 1);

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                paused_q, paused_d;
    logic                rep_pend_q, rep_pend_d;
    logic                nak_pend_q, nak_pend_d;
    logic                nak_frm_q, nak_frm_d;
    logic [1:0]          idx_q, idx_d;
    logic [15:0]         t_snap_q, t_snap_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [3:0]          led_q, led_d;
    logic                mute_q, mute_d;

    logic tick;
    logic c_rep, c_pause, c_resume, c_mute, c_led, c_nak;
    logic rep_set;
    logic last_byte;

    function automatic logic [7:0] rep_byte(
        input logic [1:0]  i,
        input logic [15:0] t
    );
        logic [7:0] b;
        unique case (i)
            2'd0:    b = 8'hAA;
            2'd1:    b = t[11:4];
            2'd2:    b = {4'h0, t[3:0]};
            default: b = t[11:4] ^ {4'h0, t[3:0]};
        endcase
        return b;
    endfunction

    always_comb begin
        c_rep    = 1'b0;
        c_pause  = 1'b0;
        c_resume = 1'b0;
        c_mute   = 1'b0;
        c_led    = 1'b0;
        c_nak    = 1'b0;
        if (rx_vld) begin
            unique casez (rx_data)
                8'h31:   c_rep    = 1'b1;
                8'h32:   c_pause  = 1'b1;
                8'h33:   c_resume = 1'b1;
                8'h34:   c_mute   = 1'b1;
                8'h4?:   c_led    = 1'b1;
                default: c_nak    = 1'b1;
            endcase
        end
    end

    assign tick      = (cnt_q == CNT_MAX);
    // Pause or resume arriving with the tick drops that tick.
    assign rep_set   = c_rep |
                       (tick & ~paused_q & ~c_pause & ~c_resume);
    assign last_byte = nak_frm_q | (idx_q == REP_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        paused_d   = paused_q;
        rep_pend_d = rep_pend_q;
        nak_pend_d = nak_pend_q;
        nak_frm_d  = nak_frm_q;
        idx_d      = idx_q;
        t_snap_d   = t_snap_q;
        tx_data_d  = tx_data_q;
        led_d      = led_q;
        mute_d     = mute_q;
        tx_vld     = 1'b0;

        if (c_pause)  paused_d = 1'b1;
        if (c_resume) begin
            paused_d = 1'b0;
            cnt_d    = '0;
        end
        if (c_mute) mute_d = ~mute_q;
        if (c_led)  led_d  = rx_data[3:0];

        unique case (state_q)
            IDLE: begin
                if (nak_pend_q) begin
                    nak_pend_d = 1'b0;
                    nak_frm_d  = 1'b1;
                    state_d    = LOAD;
                end else if (rep_pend_q) begin
                    rep_pend_d = 1'b0;
                    nak_frm_d  = 1'b0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                idx_d = 2'd0;
                if (!nak_frm_q) t_snap_d = t_data;
                tx_data_d = nak_frm_q ? 8'h3F : 8'hAA;
                state_d   = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_vld  = 1'b1;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (tx_busy) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_byte) begin
                        state_d = IDLE;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        tx_data_d = rep_byte(idx_q + 2'd1, t_snap_q);
                        state_d   = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // New requests win over the IDLE clear so none is lost.
        if (rep_set) rep_pend_d = 1'b1;
        if (c_nak)   nak_pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            paused_q   <= 1'b0;
            rep_pend_q <= 1'b0;
            nak_pend_q <= 1'b0;
            nak_frm_q  <= 1'b0;
            idx_q      <= 2'd0;
            t_snap_q   <= 16'h0000;
            tx_data_q  <= 8'h00;
            led_q      <= 4'h0;
            mute_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            paused_q   <= paused_d;
            rep_pend_q <= rep_pend_d;
            nak_pend_q <= nak_pend_d;
            nak_frm_q  <= nak_frm_d;
            idx_q      <= idx_d;
            t_snap_q   <= t_snap_d;
            tx_data_q  <= tx_data_d;
            led_q      <= led_d;
            mute_q     <= mute_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign led       = led_q;
    assign beep_mute = mute_q;

endmodule

// File: tb/tb_tel_sched.sv
// tb_tel_sched: self-checking bench for tel_sched with a uart_tx model.
// Vector table plus hand sequences plus randomized commands.
module tb_tel_sched;

    localparam int PER  = 100;
    localparam int BUSY = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] t_data = 16'h0198;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_vld = 1'b0;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic [3:0]  led;
    logic        beep_mute;

    always #5 clk = ~clk;

    tel_sched #(.PERIOD(PER), .PERIOD_W(27)) dut (
        .clk      (clk),
        .rst      (rst),
        .t_data   (t_data),
        .rx_data  (rx_data),
        .rx_vld   (rx_vld),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_vld   (tx_vld),
        .led      (led),
        .beep_mute(beep_mute)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx model: busy rises the cycle after acceptance, lasts BUSY cycles.
    int         busy_cnt = 0;
    int         vb_err = 0;
    logic [7:0] got_q[$];
    int         got_c[$];
    assign tx_busy = (busy_cnt != 0);

    always @(posedge clk) begin
        if (tx_vld && tx_busy) begin
            vb_err <= vb_err + 1;
        end else if (tx_vld) begin
            busy_cnt <= BUSY;
            got_q.push_back(tx_data);
            got_c.push_back(cyc);
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    int passed = 0;
    int total  = 0;
    int fstart = 0;
    logic [3:0] m_led  = 4'h0;
    logic       m_mute = 1'b0;

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] t;
        logic [3:0]  led;
        logic        mute;
        int          frm;  // 0 none, 1 report, 2 nak
    } vec_t;
    vec_t tbl[15];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic quiet(input string nm, input int n);
        idle(n);
        check(nm, got_q.size(), 0);
        got_q.delete();
        got_c.delete();
    endtask

    function automatic int flen(input bit nak);
`ifdef TEL_CHECKSUM_EN
        return nak ? 1 : 4;
`else
        return nak ? 1 : 3;
`endif
    endfunction

    function automatic logic [7:0] fbyte(input bit nak,
                                         input logic [15:0] t,
                                         input int i);
        logic [7:0] hi, lo;
        hi = t[11:4];
        lo = {4'h0, t[3:0]};
        if (nak) return 8'h3F;
        if (i == 0) return 8'hAA;
        if (i == 1) return hi;
        if (i == 2) return lo;
        return hi ^ lo;
    endfunction

    task automatic exp_byte(input string nm, input logic [7:0] e,
                            output int c);
        int n = 0;
        while (got_q.size() == 0 && n < 300) begin
            idle(1);
            n++;
        end
        if (got_q.size() == 0) begin
            total++;
            c = 0;
            $display("FAIL %s: timeout, no byte, expected %02h", nm, e);
        end else begin
            c = got_c.pop_front();
            check(nm, got_q.pop_front(), e);
        end
    endtask

    task automatic expect_frame(input string nm, input bit nak,
                                input logic [15:0] t);
        int c;
        for (int i = 0; i < flen(nak); i++) begin
            exp_byte($sformatf("%s[%0d]", nm, i), fbyte(nak, t, i), c);
            if (i == 0) fstart = c;
        end
    endtask

    task automatic send(input logic [7:0] b, output int n);
        n       = cyc;
        rx_data = b;
        rx_vld  = 1'b1;
        idle(1);
        rx_vld  = 1'b0;
    endtask

    // Strobe a command; led/mute must be old in cycle N, new in N+1.
    task automatic strobe_chk(input string nm, input logic [7:0] b,
                              input logic [3:0] nl, input logic nm_);
        rx_data = b;
        rx_vld  = 1'b1;
        check({nm, "_led_old"}, led, m_led);
        check({nm, "_mute_old"}, beep_mute, m_mute);
        idle(1);
        rx_vld  = 1'b0;
        check({nm, "_led"}, led, nl);
        check({nm, "_mute"}, beep_mute, nm_);
        m_led  = nl;
        m_mute = nm_;
    endtask

    function automatic bit is_cmd(input logic [7:0] b);
        return (b >= 8'h31 && b <= 8'h34) || (b >= 8'h40 && b <= 8'h4F);
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, n, s0, c;
        tbl[0]  = '{8'h4A, 16'h0198, 4'hA, 1'b0, 0};
        tbl[1]  = '{8'h34, 16'h0198, 4'hA, 1'b1, 0};
        tbl[2]  = '{8'h34, 16'h0198, 4'hA, 1'b0, 0};
        tbl[3]  = '{8'h31, 16'h0198, 4'hA, 1'b0, 1};
        tbl[4]  = '{8'h55, 16'h0198, 4'hA, 1'b0, 2};
        tbl[5]  = '{8'h4F, 16'h0198, 4'hF, 1'b0, 0};
        tbl[6]  = '{8'h40, 16'h0198, 4'h0, 1'b0, 0};
        tbl[7]  = '{8'h31, 16'hFF80, 4'h0, 1'b0, 1};
        tbl[8]  = '{8'h00, 16'h0198, 4'h0, 1'b0, 2};
        tbl[9]  = '{8'hFF, 16'h0198, 4'h0, 1'b0, 2};
        tbl[10] = '{8'h50, 16'h0198, 4'h0, 1'b0, 2};
        tbl[11] = '{8'h34, 16'h0198, 4'h0, 1'b1, 0};
        tbl[12] = '{8'h31, 16'h07FF, 4'h0, 1'b1, 1};
        tbl[13] = '{8'h35, 16'h0198, 4'h0, 1'b1, 2};
        tbl[14] = '{8'h32, 16'h0198, 4'h0, 1'b1, 0};

        idle(3);
        check("rst_tx_vld", tx_vld, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_led", led, 0);
        check("rst_mute", beep_mute, 0);
        rst = 1'b0;
        r = cyc;

        // Periodic reports and tick latency.
        expect_frame("per0", 0, 16'h0198);
        s0 = fstart;
        check("tick_lat", s0 - r, PER + 2);
        expect_frame("per1", 0, 16'h0198);
        check("period", fstart - s0, PER);

        // NAK strobed in the tick cycle: NAK first, then the report.
        s0 = fstart - 3 + PER;
        while (cyc < s0) idle(1);
        send(8'h55, n);
        expect_frame("nak_first", 1, 16'h0198);
        check("nak_lat", fstart - n, 3);
        expect_frame("rep_after_nak", 0, 16'h0198);
        send(8'h32, n);
        quiet("paused_quiet", 3 * PER);

        // Vector table, all while paused.
        foreach (tbl[i]) begin
            t_data = tbl[i].t;
            strobe_chk($sformatf("v%0d", i), tbl[i].cmd,
                       tbl[i].led, tbl[i].mute);
            if (tbl[i].frm == 1)
                expect_frame($sformatf("v%0d_rep", i), 0, tbl[i].t);
            else if (tbl[i].frm == 2)
                expect_frame($sformatf("v%0d_nak", i), 1, tbl[i].t);
            idle(30);
        end
        quiet("tbl_quiet", 50);
        t_data = 16'h0198;

        // Command latency.
        send(8'h31, n);
        expect_frame("cmd31", 0, 16'h0198);
        check("cmd_lat", fstart - n, 3);
        idle(30);

        // Mid-frame requests coalesce into one extra frame.
        send(8'h31, n);
        idle(10);
        send(8'h31, n);
        idle(20);
        send(8'h31, n);
        expect_frame("coal_a", 0, 16'h0198);
        expect_frame("coal_b", 0, 16'h0198);
        quiet("coal_quiet", 150);

        // Bad byte during a report: report intact, then NAK.
        send(8'h31, n);
        idle(10);
        send(8'h55, n);
        expect_frame("nak_mid_rep", 0, 16'h0198);
        expect_frame("nak_mid_nak", 1, 16'h0198);
        quiet("nak_quiet", 100);

        // t_data change after byte 0 must not leak into the frame.
        send(8'h31, n);
        exp_byte("snap[0]", 8'hAA, c);
        t_data = 16'hFF80;
        for (int i = 1; i < flen(0); i++)
            exp_byte($sformatf("snap[%0d]", i), fbyte(0, 16'h0198, i), c);
        t_data = 16'h0198;
        quiet("snap_quiet", 60);

        // Resume: report exactly one period later.
        send(8'h33, n);
        expect_frame("resume", 0, 16'h0198);
        check("resume_lat", fstart - n, PER + 3);
        send(8'h32, n);
        quiet("repause_quiet", 2 * PER);

        // Reset in WAIT_LO of byte 1.
        strobe_chk("pre_rst_a", 8'h4C, 4'hC, m_mute);
        if (!m_mute) strobe_chk("pre_rst_b", 8'h34, 4'hC, 1'b1);
        send(8'h31, n);
        exp_byte("rst_frm[0]", 8'hAA, c);
        exp_byte("rst_frm[1]", 8'h19, c);
        idle(10);
        rst = 1'b1;
        idle(1);
        check("mrst_tx_vld", tx_vld, 0);
        check("mrst_tx_data", tx_data, 0);
        check("mrst_led", led, 0);
        check("mrst_mute", beep_mute, 0);
        rst = 1'b0;
        m_led  = 4'h0;
        m_mute = 1'b0;
        quiet("post_rst_quiet", 80);
        send(8'h32, n);
        idle(30);

        // Randomized commands against the model.
        for (int i = 0; i < 24; i++) begin
            int k;
            logic [7:0]  b;
            logic [15:0] t;
            logic [3:0]  nl;
            logic        nmu;
            k = $urandom_range(0, 3);
            t = 16'($urandom);
            t_data = t;
            if (k == 0) b = 8'h31;
            else if (k == 1) b = 8'h40 | 8'($urandom_range(0, 15));
            else if (k == 2) b = 8'h34;
            else begin
                b = 8'($urandom_range(0, 255));
                while (is_cmd(b)) b = 8'($urandom_range(0, 255));
            end
            nl  = (b >= 8'h40 && b <= 8'h4F) ? b[3:0] : m_led;
            nmu = (b == 8'h34) ? ~m_mute : m_mute;
            strobe_chk($sformatf("r%0d", i), b, nl, nmu);
            if (k == 0) expect_frame($sformatf("r%0d_rep", i), 0, t);
            if (k == 3) expect_frame($sformatf("r%0d_nak", i), 1, t);
            idle(5 + $urandom_range(0, 20));
        end
        quiet("rand_quiet", 80);

        check("vld_while_busy", vb_err, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
